// File: rtl/nibble_stream_pkg.sv
// Shared types for the nibble-stream initiator.
// State encoding and nibble width.
package nibble_stream_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_COLLECT,
    ST_GAP
  } state_t;

endpackage

// File: rtl/nibble_stream_initiator_collector.sv
// Response collector: shifts in the DUT burst LSN-first,
// reports completion and bursts that end early.
module nibble_collector
  import nibble_stream_pkg::*;
#(
  parameter int RESP_NIB = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      vld,
  input  logic [NIB_W-1:0]          nib,
  output logic                      done,
  output logic                      short_burst,
  output logic                      resp_valid,
  output logic [RESP_NIB*NIB_W-1:0] resp_data
);

  localparam int RW = RESP_NIB * NIB_W;
  localparam int CW = $clog2(RESP_NIB) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RESP_NIB - 1);

  logic [RW-1:0] sh_q, sh_d;
  logic [RW-1:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rv_q, rv_d;

  always_comb begin
    sh_d        = sh_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    rv_d        = 1'b0;
    done        = 1'b0;
    short_burst = 1'b0;
    if (!en) begin
      cnt_d = '0;
    end else if (vld) begin
      // new nibble enters at the top so the first one ends in [3:0]
      sh_d = RW'({nib, sh_q} >> NIB_W);
      if (cnt_q == CNT_LAST) begin
        done   = 1'b1;
        rv_d   = 1'b1;
        data_d = sh_d;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (cnt_q != '0) begin
      short_burst = 1'b1;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      data_q <= '0;
      cnt_q  <= '0;
      rv_q   <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
      rv_q   <= rv_d;
    end
  end

  assign resp_valid = rv_q;
  assign resp_data  = data_q;

endmodule

// File: rtl/nibble_stream_initiator.sv
// Initiator for the 4-bit nibble-stream test interface:
// sends one frame, collects the reply, flags timeout/protocol errors.
module nibble_stream_initiator
  import nibble_stream_pkg::*;
#(
  parameter int FRAME_NIB = 16,
  parameter int RESP_NIB  = 4,
  parameter int TIMEOUT   = 1000,
  parameter int GAP       = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frm_valid,
  output logic                       frm_ready,
  input  logic [FRAME_NIB*NIB_W-1:0] frm_data,
  output logic                       in_valid,
  output logic [NIB_W-1:0]           in,
  input  logic                       out_valid,
  input  logic [NIB_W-1:0]           out,
  output logic                       resp_valid,
  output logic [RESP_NIB*NIB_W-1:0]  resp_data,
  output logic                       timeout,
  output logic                       proto_err
);

  localparam int FW = FRAME_NIB * NIB_W;
  localparam int SW = $clog2(FRAME_NIB) + 1;
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam int GW = $clog2(GAP + 1) + 1;
  localparam logic [SW-1:0] SEND_LAST = SW'(FRAME_NIB - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam state_t        POST      = (GAP > 0) ? ST_GAP : ST_IDLE;

  state_t        state_q, state_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [SW-1:0] send_cnt_q, send_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;

  logic col_en;
  logic col_done;
  logic col_short;
  logic stray;

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    send_cnt_d = send_cnt_q;
    wait_cnt_d = wait_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    frm_ready  = 1'b0;
    in_valid   = 1'b0;
    in         = '0;
    timeout    = 1'b0;
    stray      = 1'b0;
    col_en     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        frm_ready = 1'b1;
        stray     = out_valid;
        if (frm_valid) begin
          frame_d    = frm_data;
          send_cnt_d = '0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        in_valid = 1'b1;
        in       = frame_q[NIB_W-1:0];
        stray    = out_valid;
        frame_d  = frame_q >> NIB_W;
        if (send_cnt_q == SEND_LAST) begin
          wait_cnt_d = '0;
          state_d    = ST_WAIT;
        end else begin
          send_cnt_d = send_cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        col_en    = 1'b1;
        gap_cnt_d = '0;
        // a reply on the last allowed cycle still counts as a reply
        if (out_valid) begin
          state_d = col_done ? POST : ST_COLLECT;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout = 1'b1;
          state_d = POST;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_COLLECT: begin
        col_en    = 1'b1;
        gap_cnt_d = '0;
        if (col_done || col_short) begin
          state_d = POST;
        end
      end
      ST_GAP: begin
        stray = out_valid;
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      frame_q    <= '0;
      send_cnt_q <= '0;
      wait_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      send_cnt_q <= send_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  nibble_collector #(
    .RESP_NIB(RESP_NIB)
  ) u_collector (
    .clk        (clk),
    .rst        (rst),
    .en         (col_en),
    .vld        (out_valid),
    .nib        (out),
    .done       (col_done),
    .short_burst(col_short),
    .resp_valid (resp_valid),
    .resp_data  (resp_data)
  );

  assign proto_err = stray | col_short;

endmodule

// File: tb/tb_nibble_stream_initiator.sv
// Directed bench for nibble_stream_initiator:
// reset, basic, timeout, short burst, stray data, back-to-back.
module tb_nibble_stream_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frm_valid = 1'b0;
  logic        frm_ready;
  logic [63:0] frm_data = '0;
  logic        in_valid;
  logic [3:0]  in;
  logic        out_valid = 1'b0;
  logic [3:0]  out = '0;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        timeout;
  logic        proto_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nibble_stream_initiator #(
    .FRAME_NIB(16),
    .RESP_NIB (4),
    .TIMEOUT  (1000),
    .GAP      (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .frm_valid (frm_valid),
    .frm_ready (frm_ready),
    .frm_data  (frm_data),
    .in_valid  (in_valid),
    .in        (in),
    .out_valid (out_valid),
    .out       (out),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .timeout   (timeout),
    .proto_err (proto_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic ov, input logic [3:0] o);
    @(negedge clk);
    out_valid = ov;
    out       = o;
    #1;
  endtask

  task automatic start(input logic [63:0] d, input logic hold,
                       input int stray_at, output logic [63:0] got,
                       output int vcnt, output int perr, output int rdy);
    @(negedge clk);
    frm_valid = 1'b1;
    frm_data  = d;
    out_valid = 1'b0;
    #1;
    chk("hs_rdy", frm_ready, 1);
    got = '0; vcnt = 0; perr = 0; rdy = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      frm_valid = hold;
      out_valid = (i == stray_at);
      out       = 4'hA;
      #1;
      got[4*i +: 4] = in;
      vcnt += int'(in_valid);
      perr += int'(proto_err);
      rdy  += int'(frm_ready);
    end
  endtask

  task automatic xact(input string tag, input logic [63:0] d,
                      input logic [15:0] r, input logic hold,
                      input int lat, input int stray_at);
    logic [63:0] got;
    int vcnt, perr, rdy, idle_bad;
    start(d, hold, stray_at, got, vcnt, perr, rdy);
    chk({tag, ".stream"}, got, d);
    chk({tag, ".vcnt"}, vcnt, 16);
    idle_bad = 0;
    for (int i = 0; i < lat; i++) begin
      cyc(0, 0);
      idle_bad += int'(in_valid !== 1'b0 || in !== 4'h0);
      rdy      += int'(frm_ready);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1, r[4*i +: 4]);
      idle_bad += int'(in_valid !== 1'b0 || in !== 4'h0);
      rdy      += int'(frm_ready);
      perr     += int'(proto_err);
    end
    chk({tag, ".idle"}, idle_bad, 0);
    cyc(0, 0);
    chk({tag, ".rv"}, resp_valid, 1);
    chk({tag, ".rd"}, resp_data, r);
    rdy += int'(frm_ready);
    cyc(0, 0);
    chk({tag, ".rv_off"}, resp_valid, 0);
    chk({tag, ".rd_hold"}, resp_data, r);
    rdy += int'(frm_ready);
    chk({tag, ".busy_rdy"}, rdy, 0);
    chk({tag, ".perr"}, perr, (stray_at >= 0) ? 1 : 0);
  endtask

  logic [63:0] got;
  int v, p, rd, to_at, rv_seen, to_seen;

  initial begin
    // reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_rdy", frm_ready, 1);
    chk("rst_iv", in_valid, 0);
    chk("rst_rd", resp_data, 0);
    @(negedge clk);
    rst = 1'b0;

    // reset in the middle of SEND
    @(negedge clk);
    frm_valid = 1'b1;
    frm_data  = 64'hAAAA_5555_AAAA_5555;
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      frm_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_iv", in_valid, 0);
    chk("mrst_in", in, 0);
    chk("mrst_rdy", frm_ready, 1);
    chk("mrst_pulses", {resp_valid, timeout, proto_err}, 0);
    chk("mrst_rd", resp_data, 0);
    cyc(0, 0);
    chk("mrst_iv2", in_valid, 0);

    // basic: reply 3 cycles after the last nibble
    xact("basic", 64'hFEDC_BA98_7654_3210, 16'h1234, 1'b0, 2, -1);
    cyc(0, 0);
    chk("basic_rdy_back", frm_ready, 1);

    // timeout
    start(64'h1357_9BDF_0246_8ACE, 1'b0, -1, got, v, p, rd);
    chk("to_stream", got, 64'h1357_9BDF_0246_8ACE);
    to_at = 0;
    rv_seen = 0;
    for (int n = 1; n <= 1100 && to_at == 0; n++) begin
      cyc(0, 0);
      rv_seen += int'(resp_valid);
      if (timeout) to_at = n;
    end
    chk("to_cycle", to_at, 1000);
    cyc(0, 0);
    chk("to_off", timeout, 0);
    chk("to_gap_rdy", frm_ready, 0);
    rv_seen += int'(resp_valid);
    cyc(0, 0);
    rv_seen += int'(resp_valid);
    cyc(0, 0);
    chk("to_idle_rdy", frm_ready, 1);
    chk("to_no_rv", rv_seen, 0);

    // short burst: 2 of 4 nibbles
    start(64'h0F0F_0F0F_0F0F_0F0F, 1'b0, -1, got, v, p, rd);
    cyc(1, 4'h5);
    cyc(1, 4'h6);
    chk("sb_perr_early", proto_err, 0);
    cyc(0, 0);
    chk("sb_perr", proto_err, 1);
    cyc(0, 0);
    chk("sb_perr_once", proto_err, 0);
    chk("sb_no_rv", resp_valid, 0);
    cyc(0, 0);
    chk("sb_gap_rdy", frm_ready, 0);
    cyc(0, 0);
    chk("sb_idle_rdy", frm_ready, 1);
    chk("sb_rd_hold", resp_data, 16'h1234);

    // stray nibble in SEND, then in IDLE
    xact("stray", 64'h0123_4567_89AB_CDEF, 16'h6789, 1'b0, 0, 5);
    cyc(1, 4'hC);
    chk("stray_idle_perr", proto_err, 1);
    chk("stray_idle_rdy", frm_ready, 1);
    cyc(0, 0);
    chk("stray_idle_off", proto_err, 0);

    // reply lands on the same cycle the timeout would fire
    start(64'h2222_3333_4444_5555, 1'b0, -1, got, v, p, rd);
    to_seen = 0;
    for (int n = 0; n < 999; n++) begin
      cyc(0, 0);
      to_seen += int'(timeout);
    end
    cyc(1, 4'h1);
    chk("sim_to", timeout, 0);
    chk("sim_to_early", to_seen, 0);
    cyc(1, 4'h2);
    cyc(1, 4'h3);
    cyc(1, 4'h4);
    cyc(0, 0);
    chk("sim_rv", resp_valid, 1);
    chk("sim_rd", resp_data, 16'h4321);
    cyc(0, 0);
    cyc(0, 0);

    // back-to-back with frm_valid held high
    xact("b2b0", 64'h1111_2222_3333_4444, 16'hA5C3, 1'b1, 1, -1);
    xact("b2b1", 64'h9876_5432_10FE_DCBA, 16'h0FF0, 1'b1, 0, -1);
    xact("b2b2", 64'hDEAD_BEEF_CAFE_F00D, 16'h7E81, 1'b1, 3, -1);
    @(negedge clk);
    frm_valid = 1'b0;
    #1;
    chk("b2b_end_rdy", frm_ready, 1);
    cyc(0, 0);
    chk("b2b_end_iv", in_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
